// File: rtl/rvm_mem_arb_pkg.sv
// Shared definitions for the rvm_mem_arb memory-bus arbiter.
//   RVM_ARB_FIXED / RVM_ARB_RR : values for the ARB_MODE parameter.
//   arb_ev_e                   : what the granted transaction does this cycle.
//   next_port()                : round-robin successor of a port index.
package rvm_mem_arb_pkg;

    localparam int RVM_ARB_FIXED = 0;
    localparam int RVM_ARB_RR    = 1;

    typedef enum logic [1:0] {
        ARB_EV_IDLE  = 2'd0,  // nobody is using the bus
        ARB_EV_DONE  = 2'd1,  // winner completes this cycle
        ARB_EV_WAIT  = 2'd2,  // winner is held off by mem_stall
        ARB_EV_ABORT = 2'd3   // stalled owner withdrew its request
    } arb_ev_e;

    function automatic int next_port(input int cur, input int n);
        return (cur + 1) % n;
    endfunction

endpackage

// File: rtl/rvm_arb_pick.sv
// Combinational picker: finds the first set bit of req, searching upward
// from index start and wrapping modulo NUM_PORTS.
//   req   : request vector
//   start : index where the search begins (highest priority this cycle)
//   gnt   : one-hot of the chosen port, zero when req is empty
//   idx   : index of the chosen port, zero when req is empty
module rvm_arb_pick #(
    parameter  int NUM_PORTS = 2,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     start,
    output logic [NUM_PORTS-1:0] gnt,
    output logic [IDX_W-1:0]     idx
);

    logic found;
    int   pos;

    // Rotate, priority-encode and rotate back, folded into one walk: the
    // offset from start is the rotated position, pos the un-rotated one.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            pos = (int'(start) + off) % NUM_PORTS;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/rvm_mem_arb.sv
// N-port arbiter sharing one single-ported rvm_core memory bus.
//   clk, resetn         : clock, asynchronous active-low reset
//   req_*               : packed per-port requests (c_en, w_en, lock, addr,
//                         wdata, b_en), port k at slice k
//   req_rdata           : read data broadcast to every port
//   req_stall/req_error : per-port stall and completion error
//   mem_*               : downstream bus; mem_rdata/error/stall come back
//   grant               : one-hot current owner, zero when the bus is idle
// The winner's request is muxed straight to mem_* in the same cycle. A
// stalled winner keeps the bus (locked), and a completion with req_lock set
// keeps it across following transactions (atomic).
module rvm_mem_arb
    import rvm_mem_arb_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int ARB_MODE  = RVM_ARB_RR,
    localparam int BE_W      = DATA_W / 8,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [NUM_PORTS-1:0]        req_c_en,
    input  logic [NUM_PORTS-1:0]        req_w_en,
    input  logic [NUM_PORTS-1:0]        req_lock,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
    input  logic [NUM_PORTS*BE_W-1:0]   req_b_en,
    output logic [DATA_W-1:0]           req_rdata,
    output logic [NUM_PORTS-1:0]        req_stall,
    output logic [NUM_PORTS-1:0]        req_error,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [BE_W-1:0]             mem_b_en,
    output logic                        mem_c_en,
    output logic                        mem_w_en,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_error,
    input  logic                        mem_stall,
    output logic [NUM_PORTS-1:0]        grant
);

    logic             locked_q, locked_d;
    logic             atomic_q, atomic_d;
    logic [IDX_W-1:0] owner_q,  owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    logic [IDX_W-1:0]     pick_start, pick_idx, win_idx;
    logic [NUM_PORTS-1:0] pick_gnt, held_gnt;
    logic                 arb_free, win_valid;
    logic                 sel_cen, sel_wen, sel_lock;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [BE_W-1:0]      sel_ben;
    arb_ev_e              ev;

    // Fresh arbitration only when nobody holds the bus.
    assign arb_free   = !locked_q && !atomic_q;
    assign pick_start = (ARB_MODE == RVM_ARB_RR) ? rr_ptr_q : '0;
    assign win_idx    = arb_free ? pick_idx : owner_q;

    rvm_arb_pick #(
        .NUM_PORTS(NUM_PORTS)
    ) u_pick (
        .req  (req_c_en),
        .start(pick_start),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Select the winner's request fields.
    always_comb begin
        sel_cen   = 1'b0;
        sel_wen   = 1'b0;
        sel_lock  = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_ben   = '0;
        held_gnt  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            held_gnt[k] = (IDX_W'(k) == owner_q);
            if (IDX_W'(k) == win_idx) begin
                sel_cen   = req_c_en[k];
                sel_wen   = req_w_en[k];
                sel_lock  = req_lock[k];
                sel_addr  = req_addr[k*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[k*DATA_W +: DATA_W];
                sel_ben   = req_b_en[k*BE_W +: BE_W];
            end
        end
    end

    // Reset forces the bus idle so every requester simply sees a stall.
    assign win_valid = resetn && sel_cen;

    // Downstream bus depends only on requests and state, never on mem_*.
    always_comb begin
        mem_c_en  = win_valid;
        mem_w_en  = win_valid && sel_wen;
        mem_addr  = win_valid ? sel_addr  : '0;
        mem_wdata = win_valid ? sel_wdata : '0;
        mem_b_en  = win_valid ? sel_ben   : '0;
        grant     = '0;
        if (win_valid) begin
            grant = arb_free ? pick_gnt : held_gnt;
        end
    end

    assign req_rdata = mem_rdata;

    always_comb begin
        req_stall = '0;
        req_error = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            req_stall[k] = req_c_en[k] && !(grant[k] && !mem_stall);
            req_error[k] = grant[k] && !mem_stall && mem_error;
        end
    end

    always_comb begin
        if (win_valid) begin
            ev = mem_stall ? ARB_EV_WAIT : ARB_EV_DONE;
        end else if (locked_q) begin
            ev = ARB_EV_ABORT;
        end else begin
            ev = ARB_EV_IDLE;
        end
    end

    always_comb begin
        locked_d = locked_q;
        atomic_d = atomic_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (ev)
            ARB_EV_DONE: begin
                locked_d = 1'b0;
                atomic_d = sel_lock;
                owner_d  = win_idx;
                rr_ptr_d = IDX_W'(next_port(int'(win_idx), NUM_PORTS));
            end
            ARB_EV_WAIT: begin
                locked_d = 1'b1;
                owner_d  = win_idx;
            end
            ARB_EV_ABORT: begin
                locked_d = 1'b0;
            end
            default: begin
                // Idle owner releasing its lock ends the atomic sequence.
                if (atomic_q && !sel_lock) begin
                    atomic_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            locked_q <= 1'b0;
            atomic_q <= 1'b0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            locked_q <= locked_d;
            atomic_q <= atomic_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_rvm_mem_arb.sv
module tb_rvm_mem_arb;
    localparam int NP = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int BUSW = 2 + AW + DW + BW;

    logic clk, resetn;
    logic [NP-1:0] c_en, w_en, lock;
    logic [NP*AW-1:0] addr_p;
    logic [NP*DW-1:0] wdata_p;
    logic [NP*BW-1:0] ben_p;
    logic [DW-1:0] mem_rdata;
    logic mem_error, mem_stall;

    logic [DW-1:0] req_rdata, fx_req_rdata;
    logic [NP-1:0] req_stall, req_error, grant, fx_req_stall, fx_req_error, fx_grant;
    logic [AW-1:0] mem_addr, fx_mem_addr;
    logic [DW-1:0] mem_wdata, fx_mem_wdata;
    logic [BW-1:0] mem_b_en, fx_mem_b_en;
    logic mem_c_en, mem_w_en, fx_mem_c_en, fx_mem_w_en;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state (round-robin arbiter)
    int m_owner, m_rr;
    bit m_locked, m_atomic;
    int e_win;
    bit e_active;
    logic [NP-1:0] e_grant, e_stall, e_error;
    logic [BUSW-1:0] e_bus;

    rvm_mem_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1)) dut (
        .clk(clk), .resetn(resetn), .req_c_en(c_en), .req_w_en(w_en), .req_lock(lock),
        .req_addr(addr_p), .req_wdata(wdata_p), .req_b_en(ben_p), .req_rdata(req_rdata),
        .req_stall(req_stall), .req_error(req_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_b_en(mem_b_en), .mem_c_en(mem_c_en), .mem_w_en(mem_w_en), .mem_rdata(mem_rdata),
        .mem_error(mem_error), .mem_stall(mem_stall), .grant(grant));

    rvm_mem_arb #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0)) dut_fx (
        .clk(clk), .resetn(resetn), .req_c_en(c_en), .req_w_en(w_en), .req_lock(lock),
        .req_addr(addr_p), .req_wdata(wdata_p), .req_b_en(ben_p), .req_rdata(fx_req_rdata),
        .req_stall(fx_req_stall), .req_error(fx_req_error), .mem_addr(fx_mem_addr),
        .mem_wdata(fx_mem_wdata), .mem_b_en(fx_mem_b_en), .mem_c_en(fx_mem_c_en),
        .mem_w_en(fx_mem_w_en), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .mem_stall(mem_stall), .grant(fx_grant));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = 0; m_rr = 0; m_locked = 0; m_atomic = 0;
    endtask

    // Expected outputs for the current inputs and model state.
    task automatic model_eval();
        int cand;
        cand = -1;
        if (m_locked || m_atomic) begin
            cand = m_owner;
        end else begin
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (m_rr + i) % NP;
                if (cand < 0 && c_en[p]) cand = p;
            end
        end
        e_active = 0;
        if (cand >= 0) e_active = c_en[cand];
        e_win = cand;
        e_grant = '0;
        e_stall = c_en;
        e_error = '0;
        e_bus = '0;
        if (e_active) begin
            e_grant[cand] = 1'b1;
            e_bus = {1'b1, w_en[cand], addr_p[cand*AW +: AW], wdata_p[cand*DW +: DW], ben_p[cand*BW +: BW]};
            if (!mem_stall) begin
                e_stall[cand] = 1'b0;
                e_error[cand] = mem_error;
            end
        end
    endtask

    task automatic model_commit();
        if (e_active && !mem_stall) begin
            m_locked = 0; m_rr = (e_win + 1) % NP; m_atomic = lock[e_win]; m_owner = e_win;
        end else if (e_active) begin
            m_locked = 1; m_owner = e_win;
        end else if (m_locked) begin
            m_locked = 0;
        end else if (m_atomic && !lock[m_owner]) begin
            m_atomic = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_eval();
        model_commit();
        #1;
    endtask

    task automatic drive_idle();
        c_en = '0; w_en = '0; lock = '0; mem_stall = 0; mem_error = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1;
        model_reset();
    endtask

    task automatic test_reset();
        resetn = 0;
        drive_idle();
        addr_p = '0; wdata_p = '0; ben_p = '0; mem_rdata = '0;
        c_en = 2'b11;
        #2;
        n_checks++; if (mem_c_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_c_en: got %b want 0", mem_c_en); end
        n_checks++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_w_en: got %b want 0", mem_w_en); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
        n_checks++; if (req_stall !== 2'b11) begin n_fail++; $display("FAIL reset_req_stall: got %b want 11", req_stall); end
        n_checks++; if (req_error !== 2'b00) begin n_fail++; $display("FAIL reset_req_error: got %b want 00", req_error); end
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1;
        model_reset();
        c_en = '0;
    endtask

    task automatic test_single_read();
        c_en = 2'b01; w_en = 2'b00;
        addr_p[AW-1:0] = 32'h100;
        mem_rdata = 32'hDEAD_BEEF;
        mem_stall = 0;
        @(negedge clk);
        n_checks++; if (mem_c_en !== 1'b1) begin n_fail++; $display("FAIL single_mem_c_en: got %b want 1", mem_c_en); end
        n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL single_mem_addr: got %h want 100", mem_addr); end
        n_checks++; if (req_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", req_rdata); end
        n_checks++; if (req_stall !== 2'b00) begin n_fail++; $display("FAIL single_stall: got %b want 00", req_stall); end
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b want 01", grant); end
        n_checks++; if (mem_w_en !== 1'b0) begin n_fail++; $display("FAIL single_w_en: got %b want 0", mem_w_en); end
        tick();
        c_en = '0;
    endtask

    task automatic test_rr_alternate();
        logic [NP-1:0] want;
        do_reset();
        addr_p = {32'h200, 32'h100};
        c_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            want = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_checks++; if (grant !== want) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, grant, want); end
            n_checks++; if (mem_addr !== ((i % 2 == 0) ? 32'h100 : 32'h200)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %h", i, mem_addr); end
            n_checks++; if (fx_grant !== 2'b01) begin n_fail++; $display("FAIL fixed_grant[%0d]: got %b want 01", i, fx_grant); end
            n_checks++; if (fx_req_stall !== 2'b10) begin n_fail++; $display("FAIL fixed_stall[%0d]: got %b want 10", i, fx_req_stall); end
            tick();
        end
        c_en = '0;
    endtask

    task automatic test_stall_hold();
        do_reset();
        c_en = 2'b01;
        tick();
        c_en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            mem_stall = (i < 3);
            @(negedge clk);
            n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL stall_grant[%0d]: got %b want 10", i, grant); end
            n_checks++; if (req_stall !== ((i < 3) ? 2'b11 : 2'b01)) begin n_fail++; $display("FAIL stall_req_stall[%0d]: got %b", i, req_stall); end
            tick();
        end
        mem_stall = 0;
        c_en = 2'b01;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL stall_after_grant: got %b want 01", grant); end
        tick();
        c_en = '0;
    endtask

    task automatic test_atomic();
        logic [NP-1:0] want_g [5];
        logic [NP-1:0] want_s [5];
        logic [NP-1:0] cen_t [5];
        logic [NP-1:0] lock_t [5];
        cen_t  = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10};
        lock_t = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        want_g = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10};
        want_s = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            c_en = cen_t[i];
            lock = lock_t[i];
            @(negedge clk);
            n_checks++; if (grant !== want_g[i]) begin n_fail++; $display("FAIL atomic_grant[%0d]: got %b want %b", i, grant, want_g[i]); end
            n_checks++; if (req_stall !== want_s[i]) begin n_fail++; $display("FAIL atomic_stall[%0d]: got %b want %b", i, req_stall, want_s[i]); end
            tick();
        end
        c_en = '0; lock = '0;
    endtask

    task automatic test_error();
        do_reset();
        c_en = 2'b11;
        mem_error = 1;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL err_grant: got %b want 01", grant); end
        n_checks++; if (req_error !== 2'b01) begin n_fail++; $display("FAIL err_req_error: got %b want 01", req_error); end
        tick();
        c_en = 2'b10;
        mem_error = 0;
        @(negedge clk);
        n_checks++; if (grant !== 2'b10) begin n_fail++; $display("FAIL err_next_grant: got %b want 10", grant); end
        n_checks++; if (req_error !== 2'b00) begin n_fail++; $display("FAIL err_next_error: got %b want 00", req_error); end
        tick();
        c_en = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        c_en = 2'b01;
        tick();
        c_en = 2'b10;
        mem_stall = 1;
        tick();
        #2;
        resetn = 0;
        #1;
        n_checks++; if (mem_c_en !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_c_en: got %b want 0", mem_c_en); end
        n_checks++; if (grant !== 2'b00) begin n_fail++; $display("FAIL midrst_grant: got %b want 00", grant); end
        n_checks++; if (req_stall !== 2'b10) begin n_fail++; $display("FAIL midrst_stall: got %b want 10", req_stall); end
        @(posedge clk);
        #1;
        resetn = 1;
        model_reset();
        c_en = 2'b11;
        mem_stall = 0;
        @(negedge clk);
        n_checks++; if (grant !== 2'b01) begin n_fail++; $display("FAIL midrst_restart_grant: got %b want 01", grant); end
        tick();
        c_en = '0;
    endtask

    task automatic test_random();
        logic [NP-1:0] hold;
        do_reset();
        model_eval();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            // A stalled request stays stable until it completes.
            hold = c_en & e_stall;
            for (int k = 0; k < NP; k++) begin
                if (!hold[k]) begin
                    c_en[k] = ($urandom % 3) != 0;
                    w_en[k] = 1'($urandom % 2);
                    lock[k] = ($urandom % 4) == 0;
                    addr_p[k*AW +: AW] = $urandom;
                    wdata_p[k*DW +: DW] = $urandom;
                    ben_p[k*BW +: BW] = 4'($urandom);
                end
            end
            mem_stall = ($urandom % 4) == 0;
            mem_error = ($urandom % 5) == 0;
            mem_rdata = $urandom;
            @(negedge clk);
            model_eval();
            n_checks++; if (grant !== e_grant) begin n_fail++; $display("FAIL rand_grant@%0d: got %b want %b", cyc, grant, e_grant); end
            n_checks++; if ({mem_c_en, mem_w_en, mem_addr, mem_wdata, mem_b_en} !== e_bus) begin
                n_fail++; $display("FAIL rand_bus@%0d: got %h want %h", cyc, {mem_c_en, mem_w_en, mem_addr, mem_wdata, mem_b_en}, e_bus); end
            n_checks++; if (req_stall !== e_stall) begin n_fail++; $display("FAIL rand_stall@%0d: got %b want %b", cyc, req_stall, e_stall); end
            n_checks++; if (req_error !== e_error) begin n_fail++; $display("FAIL rand_error@%0d: got %b want %b", cyc, req_error, e_error); end
            if (e_active && !mem_stall) begin
                n_checks++; if (req_rdata !== mem_rdata) begin n_fail++; $display("FAIL rand_rdata@%0d: got %h want %h", cyc, req_rdata, mem_rdata); end
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_stall_hold();
        test_atomic();
        test_error();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
